pito_dmem_arbiter: RTL and testbench
====================================

PITO_DMEM_ARBITER -- requirements
Module: pito_dmem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (harts/DMA); legal range 2..8.
REQ-002 Parameter ADDR_W, default `PITO_DATA_MEM_ADDR_WIDTH, word address width.
REQ-003 Parameter DATA_W, default `XPR_LEN (32), data width; BE_W = DATA_W/8.
REQ-004 Parameter RD_LAT, default 1, fixed memory read latency in cycles; legal range 1..4.
REQ-005 Parameter MAX_LOCK, default 4, maximum consecutive locked grants.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req_i  input  NUM_REQ  per-requester access request.
REQ-009 we_i  input  NUM_REQ  per-requester write enable.
REQ-010 addr_i  input  NUM_REQ x ADDR_W  per-requester address.
REQ-011 wdata_i  input  NUM_REQ x DATA_W  per-requester write data.
REQ-012 be_i  input  NUM_REQ x BE_W  per-requester byte enables.
REQ-013 lock_i  input  NUM_REQ  per-requester grant-hold request.
REQ-014 gnt_o  output  NUM_REQ  one-hot grant, same cycle as accepted request.
REQ-015 rvalid_o  output  NUM_REQ  one-hot response valid to owning requester.
REQ-016 rdata_o  output  DATA_W  response data, broadcast, valid with rvalid_o.
REQ-017 mem_req_o, mem_we_o  output  1 each  memory strobe and write enable.
REQ-018 mem_addr_o / mem_wdata_o / mem_be_o  output  ADDR_W / DATA_W / BE_W  memory command.
REQ-019 mem_rdata_i  input  DATA_W  memory read data, RD_LAT cycles after mem_req_o.

Function
REQ-020 Combinational grant: at most one gnt_o bit per cycle, only to a requester with req_i high; gnt_o zero when req_i zero.
REQ-021 mem_req_o = |gnt_o; mem_we_o/addr/wdata/be mux from granted index; when no grant, command outputs zero.
REQ-022 Round-robin: search starts at index (last_gnt+1) mod NUM_REQ, ascending with wrap; last_gnt register updates only on a grant cycle.
REQ-023 A requester may be granted on consecutive cycles only if no other requester is pending or lock rule REQ-027 applies.
REQ-024 Every granted access (read or write) produces exactly one rvalid_o pulse to the same index exactly RD_LAT cycles after the grant.
REQ-025 Response tracking: RD_LAT-deep shift pipeline of {valid, index}; rdata_o = mem_rdata_i when any rvalid_o high, else zero.
REQ-026 Back-to-back grants every cycle sustain full throughput; pipeline never stalls, no backpressure on responses.

Reset
REQ-030 On rst: gnt_o, rvalid_o, rdata_o, all mem_* outputs = 0; last_gnt = NUM_REQ-1 (requester 0 wins first arbitration); lock counter = 0; response pipeline cleared.
REQ-031 Reset asserted mid-operation discards all in-flight responses; no rvalid_o pulse after rst deasserts for pre-reset grants.

Configuration
REQ-040 Macro PITO_DMEM_ARB_LOCK_EN compiles in grant locking.
REQ-027 With PITO_DMEM_ARB_LOCK_EN: if the requester granted last cycle has req_i and lock_i high and lock counter < MAX_LOCK, it is granted again regardless of round-robin; counter increments per locked grant, clears on any non-locked grant or idle cycle; at counter == MAX_LOCK round-robin resumes from that requester+1.
REQ-041 Without PITO_DMEM_ARB_LOCK_EN: lock_i ignored, no lock counter, pure round-robin per REQ-022.

Verification
REQ-050 After reset, req_i=4'b1111 held 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,... ; each rvalid_o follows its grant by RD_LAT.
REQ-051 Only req_i[2] high 5 cycles -> gnt_o=0100 every cycle, 5 rvalid_o[2] pulses, mem_addr_o tracks addr_i[2].
REQ-052 Read: requester 1 addr 0x10, mem_rdata_i=0xDEADBEEF at RD_LAT -> rvalid_o=0010, rdata_o=0xDEADBEEF for one cycle.
REQ-053 rst pulsed one cycle after grant with RD_LAT=2 -> no rvalid_o post-reset; next arbitration grants requester 0 first.
REQ-054 LOCK_EN, MAX_LOCK=4, req_i=1111, lock_i[0]=1 -> requester 0 granted 5 consecutive cycles (initial + 4 locked), then grant 0010.
REQ-055 LOCK_EN undefined, same stimulus as REQ-054 -> plain rotation 0001,0010,0100,1000.

Source files
------------

// File: rtl/pito_dmem_arbiter.sv
// pito_dmem_arbiter: round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// Define PITO_DMEM_ARB_LOCK_EN to compile in lock_i grant holding (up to MAX_LOCK repeats).
`ifndef PITO_DATA_MEM_ADDR_WIDTH
`define PITO_DATA_MEM_ADDR_WIDTH 12
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module pito_dmem_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = `PITO_DATA_MEM_ADDR_WIDTH,
    parameter int unsigned DATA_W   = `XPR_LEN,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      addr_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      wdata_i,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]    be_i,
    input  logic [NUM_REQ-1:0]                  lock_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [DATA_W-1:0]                   rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [ADDR_W-1:0]                   mem_addr_o,
    output logic [DATA_W-1:0]                   mem_wdata_o,
    output logic [DATA_W/8-1:0]                 mem_be_o,
    input  logic [DATA_W-1:0]                   mem_rdata_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BE_W  = DATA_W / 8;

    logic [IDX_W-1:0]              last_gnt_q;
    logic                          rr_found;
    logic [IDX_W-1:0]              rr_idx;
    int                            cand;
    logic [IDX_W-1:0]              cand_idx;
    logic                          lock_hit;
    logic                          gnt_valid;
    logic [IDX_W-1:0]              gnt_idx;

    logic [RD_LAT-1:0]             rsp_vld_q, rsp_vld_d;
    logic [RD_LAT-1:0][IDX_W-1:0]  rsp_idx_q, rsp_idx_d;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = int'(last_gnt_q) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            cand_idx = IDX_W'(cand);
            if (!rr_found && req_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

`ifdef PITO_DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    logic             held_q;
    logic [CNT_W-1:0] lock_cnt_q;

    // held_q marks that last_gnt_q was granted in the immediately preceding cycle.
    assign lock_hit = held_q && req_i[last_gnt_q] && lock_i[last_gnt_q] &&
                      (lock_cnt_q < CNT_W'(MAX_LOCK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            held_q     <= gnt_valid;
            lock_cnt_q <= lock_hit ? lock_cnt_q + 1'b1 : '0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock_i;
    assign lock_hit    = 1'b0;
`endif

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!rst) begin
            if (lock_hit) begin
                gnt_valid = 1'b1;
                gnt_idx   = last_gnt_q;
            end else if (rr_found) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (gnt_valid) begin
            gnt_o       = NUM_REQ'(1) << gnt_idx;
            mem_req_o   = 1'b1;
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_i[gnt_idx];
            mem_wdata_o = wdata_i[gnt_idx];
            mem_be_o    = be_i[gnt_idx];
        end
    end

    // Every grant, read or write, travels RD_LAT stages and returns one rvalid pulse.
    if (RD_LAT > 1) begin : g_shift
        assign rsp_vld_d = {rsp_vld_q[RD_LAT-2:0], gnt_valid};
        assign rsp_idx_d = {rsp_idx_q[RD_LAT-2:0], gnt_idx};
    end else begin : g_single
        assign rsp_vld_d = gnt_valid;
        assign rsp_idx_d = gnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            rsp_vld_q  <= '0;
            rsp_idx_q  <= '0;
        end else begin
            if (gnt_valid) begin
                last_gnt_q <= gnt_idx;
            end
            rsp_vld_q <= rsp_vld_d;
            rsp_idx_q <= rsp_idx_d;
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rsp_vld_q[RD_LAT-1]) begin
            rvalid_o = NUM_REQ'(1) << rsp_idx_q[RD_LAT-1];
            rdata_o  = mem_rdata_i;
        end
    end

    logic [BE_W-1:0] unused_be_w;
    assign unused_be_w = '0;

endmodule

// File: tb/tb_pito_dmem_arbiter.sv
// Self-checking bench for pito_dmem_arbiter: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pito_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int ML = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N-1:0]             req_i = '0;
    logic [N-1:0]             we_i = '0;
    logic [N-1:0]             lock_i = '0;
    logic [N-1:0][AW-1:0]     addr_i = '0;
    logic [N-1:0][DW-1:0]     wdata_i = '0;
    logic [N-1:0][DW/8-1:0]   be_i = '0;
    logic [DW-1:0]            mem_rdata_i = '0;
    logic [N-1:0]             gnt_o, rvalid_o;
    logic [DW-1:0]            rdata_o, mem_wdata_o;
    logic                     mem_req_o, mem_we_o;
    logic [AW-1:0]            mem_addr_o;
    logic [DW/8-1:0]          mem_be_o;

    pito_dmem_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (RL),
        .MAX_LOCK(ML)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .lock_i     (lock_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: who was served last, lock streak, outstanding responses.
    int m_last, m_prev, m_lcnt, m_cyc;
    bit m_lockhit;
    int q_due[$];
    int q_idx[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_last = N - 1;
        m_prev = -1;
        m_lcnt = 0;
        q_due.delete();
        q_idx.delete();
    endfunction

    function automatic int model_pick();
        m_lockhit = 1'b0;
`ifdef PITO_DMEM_ARB_LOCK_EN
        if (m_prev >= 0 && req_i[m_prev] && lock_i[m_prev] && m_lcnt < ML) begin
            m_lockhit = 1'b1;
            return m_prev;
        end
`endif
        for (int i = 1; i <= N; i++) begin
            if (req_i[(m_last + i) % N]) return (m_last + i) % N;
        end
        return -1;
    endfunction

    task automatic begin_cycle(input logic [N-1:0] r, input logic [N-1:0] w,
                               input logic [N-1:0] l);
        @(negedge clk);
        req_i  = r;
        we_i   = w;
        lock_i = l;
        for (int i = 0; i < N; i++) begin
            addr_i[i]  = AW'($urandom);
            wdata_i[i] = $urandom;
            be_i[i]    = 4'($urandom);
        end
        mem_rdata_i = $urandom;
    endtask

    task automatic finish_cycle();
        int g;
        logic [N-1:0] e_gnt, e_rv;
        #2;
        g = model_pick();
        e_gnt = (g >= 0) ? N'(1) << g : '0;
        e_rv  = '0;
        if (q_due.size() > 0 && q_due[0] == m_cyc) begin
            e_rv = N'(1) << q_idx[0];
            void'(q_due.pop_front());
            void'(q_idx.pop_front());
        end
        chk("gnt", gnt_o, e_gnt);
        chk("mem_req", mem_req_o, g >= 0);
        chk("mem_we", mem_we_o, (g >= 0) ? we_i[g] : 1'b0);
        chk("mem_addr", mem_addr_o, (g >= 0) ? addr_i[g] : '0);
        chk("mem_wdata", mem_wdata_o, (g >= 0) ? wdata_i[g] : '0);
        chk("mem_be", mem_be_o, (g >= 0) ? be_i[g] : '0);
        chk("rvalid", rvalid_o, e_rv);
        chk("rdata", rdata_o, (e_rv != 0) ? mem_rdata_i : '0);
        if (g >= 0) begin
            q_due.push_back(m_cyc + RL);
            q_idx.push_back(g);
            m_last = g;
            m_lcnt = m_lockhit ? m_lcnt + 1 : 0;
        end else begin
            m_lcnt = 0;
        end
        m_prev = g;
        m_cyc++;
    endtask

    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l);
        begin_cycle(r, w, l);
        finish_cycle();
    endtask

    // Reset held across one rising edge; all outputs must read zero even with traffic present.
    task automatic pulse_reset();
        @(negedge clk);
        rst   = 1'b1;
        req_i = '1;
        we_i  = '1;
        for (int i = 0; i < N; i++) begin
            addr_i[i]  = AW'($urandom) | 1;
            wdata_i[i] = $urandom | 1;
            be_i[i]    = 4'hF;
        end
        mem_rdata_i = 32'hA5A5A5A5;
        #2;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [N-1:0] rv;
    } vec_t;

    vec_t tbl[16];
    logic [N-1:0] lk_exp[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cyc = 0;
        model_reset();

        // Rotation with all requesting, then a lone requester, then drain (RD_LAT = 2).
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0001};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0010};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b0100};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b1000};
        tbl[6]  = '{4'b1111, 4'b0100, 4'b0001};
        tbl[7]  = '{4'b1111, 4'b1000, 4'b0010};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0100};
        tbl[9]  = '{4'b0100, 4'b0100, 4'b1000};
        tbl[10] = '{4'b0100, 4'b0100, 4'b0100};
        tbl[11] = '{4'b0100, 4'b0100, 4'b0100};
        tbl[12] = '{4'b0100, 4'b0100, 4'b0100};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0100};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0100};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0000};

`ifdef PITO_DMEM_ARB_LOCK_EN
        lk_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        lk_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif

        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            apply(tbl[k].req, 4'b0000, 4'b0000);
            chk("tbl_gnt", gnt_o, tbl[k].gnt);
            chk("tbl_rvalid", rvalid_o, tbl[k].rv);
            if (tbl[k].req == 4'b0100) chk("tbl_addr2", mem_addr_o, addr_i[2]);
        end

        // Read from requester 1 returns memory data on its rvalid only.
        pulse_reset();
        begin_cycle(4'b0010, 4'b0000, 4'b0000);
        addr_i[1] = 12'h010;
        finish_cycle();
        chk("rd_addr", mem_addr_o, 12'h010);
        apply(4'b0000, 4'b0000, 4'b0000);
        begin_cycle(4'b0000, 4'b0000, 4'b0000);
        mem_rdata_i = 32'hDEADBEEF;
        finish_cycle();
        chk("rd_rvalid", rvalid_o, 4'b0010);
        chk("rd_data", rdata_o, 32'hDEADBEEF);
        apply(4'b0000, 4'b0000, 4'b0000);
        chk("rd_done", rvalid_o, 4'b0000);

        // Reset right after a grant drops its response and restarts at requester 0.
        pulse_reset();
        apply(4'b0010, 4'b0000, 4'b0000);
        chk("mid_gnt", gnt_o, 4'b0010);
        pulse_reset();
        apply(4'b1111, 4'b0000, 4'b0000);
        chk("post_rst_gnt", gnt_o, 4'b0001);
        chk("post_rst_rv0", rvalid_o, 4'b0000);
        apply(4'b0000, 4'b0000, 4'b0000);
        chk("post_rst_rv1", rvalid_o, 4'b0000);
        apply(4'b0000, 4'b0000, 4'b0000);
        apply(4'b0000, 4'b0000, 4'b0000);

        // Requester 0 asks to hold the port while everyone is requesting.
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            apply(4'b1111, 4'b0000, 4'b0001);
            chk("lock_seq", gnt_o, lk_exp[k]);
        end

        // Randomized traffic with occasional mid-stream resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 60) == 0) pulse_reset();
            apply(N'($urandom), N'($urandom),
                  ($urandom_range(0, 1) == 0) ? N'($urandom) : N'(0));
        end
        for (int k = 0; k < RL + 1; k++) apply('0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
